// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared modes, states, width defaults and saturating helpers for layer_engine
package lenet_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int FRAC_W_DEF = 16;

  typedef enum logic [1:0] {
    MODE_CONV    = 2'd0,
    MODE_POOL    = 2'd1,
    MODE_DENSE   = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_e;

  // Clamp a wide signed value into the signed w-bit range (result sign-extended to 64 bits)
  function automatic logic signed [63:0] sat_clip(input logic signed [64:0] v, input int unsigned w);
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (v > hi) return hi[63:0];
    if (v < lo) return lo[63:0];
    return v[63:0];
  endfunction

  // Signed add of two w-bit values (passed sign-extended) saturating to the w-bit range
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [64:0] s;
    s = {a[63], a} + {b[63], b};
    return sat_clip(s, w);
  endfunction

endpackage

// File: rtl/layer_engine_if.sv
// rtl/layer_engine_if.sv - control, status and memory-port bundle between a host and layer_engine
interface layer_engine_if #(
  parameter int DATA_W = lenet_pkg::DATA_W_DEF,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) ();
  logic              start;
  logic [1:0]        mode;
  logic [DIM_W-1:0]  in_w;
  logic [DIM_W-1:0]  in_c;
  logic [DIM_W-1:0]  out_c;
  logic [DIM_W-1:0]  k;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] b_data;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_we;

  modport master (
    output start, mode, in_w, in_c, out_c, k, in_data, w_data, b_data,
    input  busy, done, err, in_addr, w_addr, b_addr, out_addr, out_data, out_we
  );

  modport slave (
    input  start, mode, in_w, in_c, out_c, k, in_data, w_data, b_data,
    output busy, done, err, in_addr, w_addr, b_addr, out_addr, out_data, out_we
  );
endinterface

// File: rtl/lenet_mac.sv
// rtl/lenet_mac.sv - multiply/scale/accumulate and max-compare datapath; LAYER_ENGINE_SAT_EN selects saturating arithmetic
module lenet_mac import lenet_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     first,
  input  mode_e                    mode,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] result
);
  logic signed [DATA_W-1:0]   acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] prod_sh;
  logic signed [DATA_W-1:0]   scaled;
  logic signed [DATA_W-1:0]   acc_sum;
  logic signed [DATA_W-1:0]   biased;

  // Full-width product rescaled to FRAC_W fraction bits, then folded into the running sum and bias
  always_comb begin
    prod    = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    prod_sh = prod >>> FRAC_W;
`ifdef LAYER_ENGINE_SAT_EN
    scaled  = DATA_W'(sat_clip(65'(prod_sh), DATA_W));
    acc_sum = DATA_W'(sat_add(64'(acc), 64'(scaled), DATA_W));
    biased  = DATA_W'(sat_add(64'(acc), 64'(bias), DATA_W));
`else
    scaled  = prod_sh[DATA_W-1:0];
    acc_sum = acc + scaled;
    biased  = acc + bias;
`endif
  end

  // Result word: pooling passes the max through, conv/dense apply bias then ReLU
  always_comb begin
    result = '0;
    if (mode == MODE_POOL) result = acc;
    else if (biased > 0)   result = biased;
  end

  // Accumulator: cleared per output; pooling keeps the strict signed maximum, first tap always loads
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (en) begin
      if (mode == MODE_POOL) begin
        if (first || (a > acc)) acc <= a;
      end else begin
        acc <= acc_sum;
      end
    end
  end

endmodule

// File: rtl/layer_engine.sv
// rtl/layer_engine.sv - CONV/POOL/DENSE layer sequencer over external memories; LAYER_ENGINE_SAT_EN enables saturation
module layer_engine import lenet_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input logic           clk,
  input logic           reset,
  layer_engine_if.slave bus
);
  state_e state, state_nxt;
  mode_e  mode_q, mode_in;

  logic [DIM_W-1:0] in_w_q, out_c_q, k_q, ic_n_q, ow_q;
  logic [DIM_W-1:0] oc, y, x, ic, ky, kx;
  logic [DIM_W-1:0] ow_in, k_in, ic_n_in;
  logic             err_q, cfg_bad;
  logic             kx_last, ky_last, ic_last, x_last, y_last, oc_last;
  logic             last_tap, last_out, first_tap;
  logic             busy_c, done_c, we_c;

  logic [ADDR_W-1:0] a_x, a_y, a_ic, a_oc, a_kx, a_ky, a_w, a_k, a_oc_n, a_ow;
  logic [ADDR_W-1:0] in_addr_c, w_addr_c, out_addr_c;
  logic signed [DATA_W-1:0] mac_result;

  // Validate the requested shape and derive output width, effective kernel and channel-loop length
  always_comb begin
    mode_in = mode_e'(bus.mode);
    cfg_bad = (mode_in == MODE_ILLEGAL) || (bus.in_w == '0) || (bus.out_c == '0);
    if ((mode_in == MODE_CONV) || (mode_in == MODE_POOL))
      cfg_bad = cfg_bad || (bus.k == '0) || (bus.k > bus.in_w);
    if (mode_in == MODE_CONV)
      cfg_bad = cfg_bad || (bus.in_c == '0);
    ow_in   = DIM_W'(1);
    k_in    = DIM_W'(1);
    ic_n_in = DIM_W'(1);
    case (mode_in)
      MODE_CONV: begin
        ow_in   = bus.in_w - bus.k + DIM_W'(1);
        k_in    = bus.k;
        ic_n_in = bus.in_c;
      end
      MODE_POOL: begin
        ow_in = (bus.k != '0) ? (bus.in_w / bus.k) : '0;
        k_in  = bus.k;
      end
      MODE_DENSE: ic_n_in = bus.in_w;
      default: ;
    endcase
  end

  assign kx_last   = (kx == k_q - DIM_W'(1));
  assign ky_last   = (ky == k_q - DIM_W'(1));
  assign ic_last   = (ic == ic_n_q - DIM_W'(1));
  assign x_last    = (x == ow_q - DIM_W'(1));
  assign y_last    = (y == ow_q - DIM_W'(1));
  assign oc_last   = (oc == out_c_q - DIM_W'(1));
  assign last_tap  = kx_last && ky_last && ic_last;
  assign last_out  = x_last && y_last && oc_last;
  assign first_tap = (ic == '0) && (ky == '0) && (kx == '0);

  // Tap and result addresses, purely from the loop counters so they hold through FETCH and MAC
  always_comb begin
    a_x    = ADDR_W'(x);
    a_y    = ADDR_W'(y);
    a_ic   = ADDR_W'(ic);
    a_oc   = ADDR_W'(oc);
    a_kx   = ADDR_W'(kx);
    a_ky   = ADDR_W'(ky);
    a_w    = ADDR_W'(in_w_q);
    a_k    = ADDR_W'(k_q);
    a_oc_n = ADDR_W'(out_c_q);
    a_ow   = ADDR_W'(ow_q);
    in_addr_c  = '0;
    w_addr_c   = '0;
    out_addr_c = a_x + a_ow * (a_y + a_ow * a_oc);
    case (mode_q)
      MODE_CONV: begin
        in_addr_c = (a_x + a_kx) + a_w * ((a_y + a_ky) + a_w * a_ic);
        w_addr_c  = a_kx + a_k * (a_ky + a_k * (a_oc + a_oc_n * a_ic));
      end
      MODE_POOL: begin
        in_addr_c = (a_x * a_k + a_kx) + a_w * ((a_y * a_k + a_ky) + a_w * a_oc);
      end
      MODE_DENSE: begin
        in_addr_c  = a_ic;
        w_addr_c   = a_oc + a_oc_n * a_ic;
        out_addr_c = a_oc;
      end
      default: ;
    endcase
  end

  // Next-state and status decode; a bad shape skips straight to DONE
  always_comb begin
    state_nxt = state;
    busy_c    = (state != S_IDLE);
    done_c    = (state == S_DONE);
    we_c      = (state == S_WRITE);
    case (state)
      S_IDLE:  if (bus.start) state_nxt = cfg_bad ? S_DONE : S_FETCH;
      S_FETCH: state_nxt = S_MAC;
      S_MAC:   state_nxt = last_tap ? S_WRITE : S_FETCH;
      S_WRITE: state_nxt = last_out ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Configuration latch, error flag and nested loop counters (oc, y, x outer; ic, ky, kx inner)
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_CONV;
      in_w_q  <= '0;
      out_c_q <= '0;
      k_q     <= '0;
      ic_n_q  <= '0;
      ow_q    <= '0;
      err_q   <= 1'b0;
      oc <= '0; y <= '0; x <= '0; ic <= '0; ky <= '0; kx <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          mode_q  <= mode_in;
          in_w_q  <= bus.in_w;
          out_c_q <= bus.out_c;
          k_q     <= k_in;
          ic_n_q  <= ic_n_in;
          ow_q    <= ow_in;
          err_q   <= cfg_bad;
          oc <= '0; y <= '0; x <= '0; ic <= '0; ky <= '0; kx <= '0;
        end
        S_MAC: begin
          if (!kx_last) kx <= kx + DIM_W'(1);
          else begin
            kx <= '0;
            if (!ky_last) ky <= ky + DIM_W'(1);
            else begin
              ky <= '0;
              ic <= ic_last ? '0 : ic + DIM_W'(1);
            end
          end
        end
        S_WRITE: begin
          if (!x_last) x <= x + DIM_W'(1);
          else begin
            x <= '0;
            if (!y_last) y <= y + DIM_W'(1);
            else begin
              y  <= '0;
              oc <= oc_last ? '0 : oc + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  lenet_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (we_c),
    .en     (state == S_MAC),
    .first  (first_tap),
    .mode   (mode_q),
    .a      (bus.in_data),
    .b      (bus.w_data),
    .bias   (bus.b_data),
    .result (mac_result)
  );

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.err      = err_q;
  assign bus.in_addr  = in_addr_c;
  assign bus.w_addr   = w_addr_c;
  assign bus.b_addr   = a_oc;
  assign bus.out_addr = out_addr_c;
  assign bus.out_we   = we_c;
  assign bus.out_data = we_c ? mac_result : '0;

endmodule

// File: doc/layer_engine.md
LAYER_ENGINE -- requirements
Module: layer_engine

Interface
REQ-001 Parameter DATA_W, default 32: signed fixed-point word width of all data, weights, biases and outputs.
REQ-002 Parameter FRAC_W, default 16: fractional bits (Q(DATA_W-FRAC_W).FRAC_W).
REQ-003 Parameter ADDR_W, default 16: width of every memory address port.
REQ-004 Parameter DIM_W, default 8: width of the runtime size fields.
REQ-005 Ports, in order:
- clk  in  1  the single clock.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  start request; accepted only in IDLE.
- mode  in  2  operation: 0=CONV, 1=POOL, 2=DENSE, 3=illegal.
- in_w  in  DIM_W  input width/height for CONV/POOL; input length for DENSE.
- in_c  in  DIM_W  input channel count (CONV only).
- out_c  in  DIM_W  output channel count (also the channel count for POOL).
- k  in  DIM_W  kernel size (CONV) or window/stride (POOL); ignored for DENSE.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky illegal-configuration flag; cleared by the next accepted start.
- in_addr, w_addr, b_addr  out  ADDR_W  read addresses for input, weight and bias memories.
- in_data, w_data, b_data  in  DATA_W  read data, valid exactly 1 cycle after the address.
- out_addr  out  ADDR_W  result write address.
- out_data  out  DATA_W  result write data.
- out_we  out  1  one-cycle write strobe.

Function
REQ-006 mode, in_w, in_c, out_c and k shall be latched on the accepted start; changes while busy shall have no effect.
REQ-007 States: IDLE -> FETCH -> MAC -> (FETCH | WRITE); WRITE -> (FETCH | DONE); DONE -> IDLE.
REQ-008 FETCH shall drive the tap addresses. MAC shall consume the data. Every tap shall cost exactly 2 cycles.
REQ-009 Output size shall be ow = in_w-k+1 (CONV), ow = in_w/k with truncation (POOL), and a single output per channel (DENSE).
REQ-010 CONV addressing:
- in_addr = x+kx + in_w*(y+ky + in_w*ic)
- w_addr = kx + k*(ky + k*(oc + out_c*ic))
- out_addr = x + ow*(y + ow*oc)
- taps per output = k*k*in_c
REQ-011 POOL addressing:
- in_addr = x*k+kx + in_w*(y*k+ky + in_w*oc)
- taps per output = k*k
- no weight or bias read
REQ-012 DENSE addressing: in_addr = ic, w_addr = oc + out_c*ic, out_addr = oc, taps per output = in_w.
REQ-013 b_addr shall equal oc and be held stable for the whole output, so that b_data is valid in WRITE.
REQ-014 Multiply: the 2*DATA_W-bit signed product shall be arithmetically shifted right by FRAC_W and truncated to DATA_W, then added to the DATA_W accumulator.
REQ-015 POOL: the first tap shall load the accumulator; each later tap shall replace it only if strictly greater (signed).
REQ-016 WRITE, CONV/DENSE: out_data = acc+b_data if that sum is >0, else 0 (ReLU).
REQ-017 WRITE, POOL: out_data = acc, with no ReLU.
REQ-018 out_we shall pulse for exactly the one WRITE cycle. The accumulator shall clear in that same cycle.
REQ-019 Loop order, outer to inner: oc, y, x, ic, ky, kx.
REQ-020 Latency: busy shall be high for exactly outputs*(2*taps+1)+1 cycles, including the DONE cycle.
REQ-021 done shall be asserted in the DONE cycle; busy shall fall in the following cycle.
REQ-022 mode=3, k=0, k>in_w or any zero size: err shall be set, done shall pulse on the next cycle, and there shall be no memory writes.
REQ-023 start while busy shall be ignored. start asserted in the same cycle as DONE shall be ignored.

Reset
REQ-024 reset shall force IDLE and clear the counters and accumulator in the same clock edge.
REQ-025 On reset, busy, done, err and out_we shall be 0; all addresses and out_data shall be 0.
REQ-026 reset mid-operation shall abort immediately. No further out_we or done shall follow it.

Configuration
REQ-027 Macro LAYER_ENGINE_SAT_EN.
- When defined: product scaling and the accumulate/bias adds shall saturate to the signed DATA_W range.
- When undefined: they shall wrap two's-complement.

Structure
REQ-028 Package lenet_pkg shall hold:
- the mode enum
- the state enum
- the DATA_W/FRAC_W defaults
- a function for the saturating add
REQ-029 Sub-module lenet_mac shall perform multiply, scale, accumulate and max-compare, selected by mode, with a clear input.

Verification
REQ-030 CONV: in_w=3, k=2, in_c=1, out_c=1; inputs 0x00010000; weights 0x00008000; bias 0 -> 4 writes of 0x00020000 at addresses 0..3; busy high for 37 cycles.
REQ-031 POOL: in_w=4, k=2, out_c=1; input ramp 0..15 (integer, Q16.16) -> writes 5,7,13,15 (Q16.16) at addresses 0..3.
REQ-032 DENSE: in_w=2, out_c=2; inputs 1.0, -2.0; weights all 1.0; bias 0 -> out[0]=out[1]=0 (ReLU of -1.0).
REQ-033 Overflow: products summing above 0x7FFFFFFF -> 0x7FFFFFFF with LAYER_ENGINE_SAT_EN defined; the wrapped value without it.
REQ-034 Error and abort:
- mode=3 -> err=1, done one cycle later, no out_we.
- reset after the 2nd write of REQ-030 -> no further out_we or done.
